// File: rtl/debug_trace_fifo_pkg.sv
// Shared field widths and entry layout for the debug trace FIFO.
package debug_trace_fifo_pkg;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned WEN_W   = 4;
  localparam int unsigned RADDR_W = 5;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ENTRY_W = PC_W + WEN_W + RADDR_W + DATA_W;  // 73

  // Packing order, MSB first: {pc, wen, addr, data}.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [WEN_W-1:0]   wen;
    logic [RADDR_W-1:0] addr;
    logic [DATA_W-1:0]  data;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo_mem.sv
// Trace storage: DEPTH x ENTRY_W, one synchronous write port, one asynchronous read port.
module trace_fifo_mem
  import debug_trace_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  // Array is deliberately not reset; occupancy lives in the pointers.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/debug_trace_fifo.sv
// Writeback trace capture FIFO: filters CPU writebacks, queues them, counts drops on overflow.
module debug_trace_fifo
  import debug_trace_fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter bit          FILTER_R0 = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PC_W-1:0]            debug_pc_addr,
  input  logic [WEN_W-1:0]           debug_reg_write_en,
  input  logic [RADDR_W-1:0]         debug_reg_write_addr,
  input  logic [DATA_W-1:0]          debug_reg_write_data,
  output logic                       trace_valid,
  input  logic                       trace_ready,
  output logic [PC_W-1:0]            trace_pc,
  output logic [WEN_W-1:0]           trace_wen,
  output logic [RADDR_W-1:0]         trace_addr,
  output logic [DATA_W-1:0]          trace_data,
  output logic [$clog2(DEPTH):0]     trace_count,
  output logic                       overflow,
  output logic [15:0]                drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_count_q, drop_count_d;

  logic          empty, full, capture, pop, push, drop;
  trace_entry_t  wr_entry, rd_entry;
  logic [ENTRY_W-1:0] rd_raw;

  // Same index with differing wrap bit means the writer has lapped the reader.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign capture = (debug_reg_write_en != '0) &&
                   (!FILTER_R0 || (debug_reg_write_addr != '0));
  assign pop     = !empty && trace_ready;
  // A pop frees the head slot this edge, so a full FIFO can still accept.
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  assign wr_entry = '{pc:   debug_pc_addr,
                      wen:  debug_reg_write_en,
                      addr: debug_reg_write_addr,
                      data: debug_reg_write_data};

  trace_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_raw)
  );

  assign rd_entry = trace_entry_t'(rd_raw);

  // Next-state for pointers, occupancy and drop accounting.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    if (push && !pop)      count_d = count_q + PW'(1);
    else if (pop && !push) count_d = count_q - PW'(1);

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
    end
  end

  // State registers; reset discards all stored entries at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign trace_valid = !empty;
  assign trace_pc    = rd_entry.pc;
  assign trace_wen   = rd_entry.wen;
  assign trace_addr  = rd_entry.addr;
  assign trace_data  = rd_entry.data;
  assign trace_count = count_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_debug_trace_fifo.sv
// Self-checking bench for debug_trace_fifo: queue reference model plus directed and random phases.
module tb_debug_trace_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic [3:0]  wen = '0;
  logic [4:0]  addr = '0;
  logic [31:0] data = '0;
  logic        ready = 1'b0;
  logic        nf_ready = 1'b0;

  logic          t_valid;
  logic [31:0]   t_pc;
  logic [3:0]    t_wen;
  logic [4:0]    t_addr;
  logic [31:0]   t_data;
  logic [CW-1:0] t_count;
  logic          t_ovf;
  logic [15:0]   t_drop;

  logic          nf_valid;
  logic [31:0]   nf_pc;
  logic [3:0]    nf_wen;
  logic [4:0]    nf_addr;
  logic [31:0]   nf_data;
  logic [CW-1:0] nf_count;
  logic          nf_ovf;
  logic [15:0]   nf_drop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debug_trace_fifo #(.DEPTH(DEPTH), .FILTER_R0(1'b1)) dut (
    .clk(clk), .rst(rst),
    .debug_pc_addr(pc), .debug_reg_write_en(wen),
    .debug_reg_write_addr(addr), .debug_reg_write_data(data),
    .trace_valid(t_valid), .trace_ready(ready),
    .trace_pc(t_pc), .trace_wen(t_wen), .trace_addr(t_addr), .trace_data(t_data),
    .trace_count(t_count), .overflow(t_ovf), .drop_count(t_drop)
  );

  // Unfiltered instance; never drained, used only to count r0 captures.
  debug_trace_fifo #(.DEPTH(DEPTH), .FILTER_R0(1'b0)) dut_nf (
    .clk(clk), .rst(rst),
    .debug_pc_addr(pc), .debug_reg_write_en(wen),
    .debug_reg_write_addr(addr), .debug_reg_write_data(data),
    .trace_valid(nf_valid), .trace_ready(nf_ready),
    .trace_pc(nf_pc), .trace_wen(nf_wen), .trace_addr(nf_addr), .trace_data(nf_data),
    .trace_count(nf_count), .overflow(nf_ovf), .drop_count(nf_drop)
  );

  task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected entries in arrival order, plus drop bookkeeping.
  logic [72:0] exp_q[$];
  bit          mdl_ovf;
  int          mdl_drops;

  // Monitor: compare DUT against the model, then advance the model by the coming edge.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      mdl_ovf   = 1'b0;
      mdl_drops = 0;
    end else begin
      bit do_pop, do_cap;
      chk("valid", 73'(t_valid), 73'(exp_q.size() > 0));
      chk("count", 73'(t_count), 73'(exp_q.size()));
      chk("overflow", 73'(t_ovf), 73'(mdl_ovf));
      chk("drop_count", 73'(t_drop), 73'(mdl_drops));
      if (t_valid && exp_q.size() > 0)
        chk("head", {t_pc, t_wen, t_addr, t_data}, exp_q[0]);
      do_pop = (exp_q.size() > 0) && ready;
      do_cap = (wen != 4'h0) && (addr != 5'd0);
      if (do_pop) void'(exp_q.pop_front());
      if (do_cap) begin
        if (exp_q.size() < DEPTH) exp_q.push_back({pc, wen, addr, data});
        else begin
          mdl_ovf = 1'b1;
          if (mdl_drops < 65535) mdl_drops++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] p, input logic [3:0] w, input logic [4:0] a,
                       input logic [31:0] d, input logic r);
    pc = p; wen = w; addr = a; data = d; ready = r;
  endtask

  task automatic idle(input logic r);
    drive(32'h0, 4'h0, 5'd0, 32'h0, r);
  endtask

  task automatic sync_reset();
    idle(1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle(1'b0);
    tick();
    tick();
    chk("rst_valid", 73'(t_valid), 73'(0));
    chk("rst_count", 73'(t_count), 73'(0));
    chk("rst_ovf", 73'(t_ovf), 73'(0));
    chk("rst_drop", 73'(t_drop), 73'(0));

    // Single capture on the first edge after reset release.
    rst = 1'b0;
    drive(32'hBFC0_0000, 4'hF, 5'd2, 32'h1234, 1'b1);
    tick();
    idle(1'b1);
    chk("single_valid", 73'(t_valid), 73'(1));
    chk("single_count", 73'(t_count), 73'(1));
    chk("single_data", 73'(t_data), 73'(32'h1234));
    chk("single_pc", 73'(t_pc), 73'(32'hBFC0_0000));
    tick();
    chk("single_valid_gone", 73'(t_valid), 73'(0));
    chk("single_count_zero", 73'(t_count), 73'(0));

    // r0 filter.
    sync_reset();
    for (int i = 0; i < 5; i++) begin
      drive(32'h100 + 32'(i), 4'hF, 5'd0, 32'(i), 1'b1);
      tick();
    end
    idle(1'b1);
    tick();
    chk("filter_count", 73'(t_count), 73'(0));
    chk("filter_valid", 73'(t_valid), 73'(0));
    chk("nofilter_count", 73'(nf_count), 73'(5));

    // Fill past capacity, then drain in order.
    sync_reset();
    for (int i = 0; i < 20; i++) begin
      drive(32'h2000 + 32'(i * 4), 4'hF, 5'(1 + i % 31), 32'(i), 1'b0);
      tick();
    end
    idle(1'b0);
    tick();
    chk("fill_count", 73'(t_count), 73'(16));
    chk("fill_ovf", 73'(t_ovf), 73'(1));
    chk("fill_drop", 73'(t_drop), 73'(4));
    idle(1'b1);
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", 73'(t_data), 73'(i));
      tick();
    end
    chk("drain_empty", 73'(t_valid), 73'(0));

    // Full with simultaneous pop across pointer wrap.
    sync_reset();
    for (int i = 0; i < 16; i++) begin
      drive(32'h3000 + 32'(i), 4'h3, 5'd7, 32'(i), 1'b0);
      tick();
    end
    for (int i = 16; i < 56; i++) begin
      drive(32'h3000 + 32'(i), 4'hC, 5'd9, 32'(i), 1'b1);
      chk("fullpop_count", 73'(t_count), 73'(16));
      chk("fullpop_order", 73'(t_data), 73'(i - 16));
      tick();
    end
    chk("fullpop_drop", 73'(t_drop), 73'(0));
    idle(1'b1);
    for (int i = 0; i < 17; i++) tick();

    // Backpressure with ready toggling.
    sync_reset();
    for (int i = 0; i < 3; i++) begin
      drive(32'h4000 + 32'(i), 4'h1, 5'd3, 32'hA0 + 32'(i), 1'b0);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      idle(1'(i % 2));
      tick();
    end
    chk("bp_empty", 73'(t_valid), 73'(0));

    // Asynchronous reset mid-run with 7 entries and overflow set.
    sync_reset();
    for (int i = 0; i < 17; i++) begin
      drive(32'h5000 + 32'(i), 4'hF, 5'd4, 32'(i), 1'b0);
      tick();
    end
    idle(1'b1);
    for (int i = 0; i < 9; i++) tick();
    idle(1'b0);
    chk("pre_rst_count", 73'(t_count), 73'(7));
    chk("pre_rst_ovf", 73'(t_ovf), 73'(1));
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 73'(t_valid), 73'(0));
    chk("arst_count", 73'(t_count), 73'(0));
    chk("arst_ovf", 73'(t_ovf), 73'(0));
    chk("arst_drop", 73'(t_drop), 73'(0));
    #1 rst = 1'b0;
    tick();
    drive(32'h6000, 4'h5, 5'd11, 32'hDEAD_BEEF, 1'b0);
    tick();
    idle(1'b1);
    chk("post_rst_data", 73'(t_data), 73'(32'hDEAD_BEEF));
    chk("post_rst_addr", 73'(t_addr), 73'(11));
    tick();

    // Random traffic, including r0 writes, idle cycles and bursts of backpressure.
    sync_reset();
    for (int i = 0; i < 500; i++) begin
      logic [3:0] w;
      logic [4:0] a;
      w = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      a = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      drive($urandom, w, a, $urandom, ($urandom_range(0, 2) != 0) && (i % 100 > 30));
      tick();
    end
    idle(1'b1);
    for (int i = 0; i < 20; i++) tick();
    chk("rand_empty", 73'(t_valid), 73'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
